// File: rtl/fetch_prefetch_pkg.sv
// Shared types and default vectors for the instruction fetch/prefetch stage.
package fetch_prefetch_pkg;

  localparam logic [31:0] DEFAULT_BOOT_ADDRESS      = 32'h0000_1000;
  localparam logic [31:0] DEFAULT_INTERRUPT_ADDRESS = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue.sv
// Prefetch FIFO of {pc, instr}; flush wins over push/pop, head is read straight from the entry registers.
module fetch_queue
  import fetch_prefetch_pkg::*;
#(
  parameter int           DEPTH       = 4,
  parameter fetch_entry_t RESET_ENTRY = '0,
  localparam int          AW          = $clog2(DEPTH),
  localparam int          CW          = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= RESET_ENTRY;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= push_entry;
        wr_ptr_reg          <= wr_ptr_reg + AW'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // The fetch credit scheme must never let a response land in a full queue.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush) assert (!(push && full && !pop));
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Pipelined Wishbone fetch master feeding a prefetch queue; redirects discard stale in-flight reads.
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS      = DEFAULT_BOOT_ADDRESS,
  parameter logic [31:0] INTERRUPT_ADDRESS = DEFAULT_INTERRUPT_ADDRESS,
  parameter int          DEPTH             = 4,
  parameter int          MAX_OUTSTANDING   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        irq_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i,
  input  logic        output_ready_i,
  output logic        output_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic          stb_reg, stb_next, cyc_reg, cyc_next, rst_q_reg;
  logic [31:0]   adr_reg, adr_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next, resp_pc_reg, resp_pc_next;
  logic [OW-1:0] outstanding_reg, outstanding_next, discard_reg, discard_next;
  logic          flush, accepting, ack, push, pop, q_full, q_empty;
  logic [31:0]   target;
  logic [CW-1:0] occupancy;
  fetch_entry_t  head;

  assign wb_adr_o       = adr_reg;
  assign wb_stb_o       = stb_reg;
  assign wb_cyc_o       = cyc_reg;
  assign wb_we_o        = 1'b0;
  assign wb_sel_o       = 4'hF;
  assign output_valid_o = !q_empty;
  assign pc_o           = head.pc;
  assign instr_o        = head.instr;
  assign pop            = !q_empty && output_ready_i;

  always_comb begin
    flush            = irq_i || branch_i;
    target           = irq_i ? INTERRUPT_ADDRESS : branch_target_i;
    accepting        = stb_reg && !wb_stall_i;
    ack              = wb_ack_i && cyc_reg;
    outstanding_next = outstanding_reg + OW'(accepting) - OW'(ack);
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    discard_next     = discard_reg;
    push             = 1'b0;
    stb_next         = 1'b0;
    if (accepting) fetch_pc_next = fetch_pc_reg + 32'd4;
    if (ack) begin
      if (discard_reg != '0) begin
        discard_next = discard_reg - OW'(1);
      end else begin
        push         = 1'b1;
        resp_pc_next = resp_pc_reg + 32'd4;
      end
    end
    if (flush) begin
      // Everything still in flight after this edge belongs to the old stream.
      fetch_pc_next = target;
      resp_pc_next  = target;
      discard_next  = outstanding_next;
      push          = 1'b0;
    end else if (stb_reg && wb_stall_i) begin
      stb_next = 1'b1;
    end else begin
      // The read limit is judged on the count that will stand after this edge.
      stb_next = (32'(outstanding_next) < 32'(MAX_OUTSTANDING)) &&
                 (32'(occupancy) + 32'(outstanding_reg) + 32'(accepting) < 32'(DEPTH));
    end
    adr_next = stb_next ? fetch_pc_next : adr_reg;
    cyc_next = stb_next || (outstanding_next != '0);
  end

  always_ff @(posedge clk_i) begin
    rst_q_reg <= rst_i;
    if (rst_i) begin
      stb_reg         <= 1'b0;
      cyc_reg         <= 1'b0;
      adr_reg         <= '0;
      fetch_pc_reg    <= BOOT_ADDRESS;
      resp_pc_reg     <= BOOT_ADDRESS;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      stb_reg         <= stb_next;
      cyc_reg         <= cyc_next;
      adr_reg         <= adr_next;
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  // A slave may still ack a read that was cut off by reset; only tolerate that right after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !rst_q_reg) assert (!wb_ack_i || cyc_reg);
  end

  fetch_queue #(
    .DEPTH       (DEPTH),
    .RESET_ENTRY (fetch_entry_t'{pc: BOOT_ADDRESS, instr: 32'h0})
  ) u_queue (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush      (flush),
    .push       (push),
    .push_entry (fetch_entry_t'{pc: resp_pc_reg, instr: wb_dat_i}),
    .pop        (pop),
    .head       (head),
    .full       (q_full),
    .empty      (q_empty),
    .count      (occupancy)
  );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: pipelined slave model plus a pc-keyed scoreboard of expected outputs.
module tb_fetch_prefetch;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        irq_i = 1'b0, branch_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic [31:0] wb_adr_o, wb_dat_i;
  logic        wb_we_o, wb_stb_o, wb_ack_i, wb_cyc_o;
  logic        wb_stall_i = 1'b0;
  logic [3:0]  wb_sel_o;
  logic        output_ready_i = 1'b0, output_valid_o;
  logic [31:0] instr_o, pc_o;

  int          checks = 0, errors = 0, acc_cnt = 0;
  bit          ack_hold = 1'b0;
  logic [31:0] pend[$];
  logic [31:0] exp_q[$];

  fetch_prefetch dut (
    .clk_i(clk_i), .rst_i(rst_i), .irq_i(irq_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
    .wb_cyc_o(wb_cyc_o), .wb_stall_i(wb_stall_i), .output_ready_i(output_ready_i),
    .output_valid_o(output_valid_o), .instr_o(instr_o), .pc_o(pc_o)
  );

  initial forever #5 clk_i = ~clk_i;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1; irq_i = 1'b0; branch_i = 1'b0; wb_stall_i = 1'b0; ack_hold = 1'b0;
    pend.delete(); exp_q.delete(); acc_cnt = 0;
    repeat (2) step();
    rst_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Slave: records accepts mid-cycle, acks them in order one cycle later unless held.
  initial forever begin
    @(negedge clk_i);
    if (!rst_i && wb_stb_o && wb_cyc_o && !wb_stall_i) begin
      pend.push_back(wb_adr_o);
      acc_cnt++;
    end
  end

  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    forever begin
      @(posedge clk_i);
      #2;
      if (!ack_hold && pend.size() != 0) begin
        wb_ack_i = 1'b1;
        wb_dat_i = instr_of(pend.pop_front());
      end else begin
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
      end
    end
  end

  // Scoreboard: every decode handshake is compared against the next expected pc.
  initial forever begin
    @(negedge clk_i);
    if (!rst_i && output_valid_o && output_ready_i && exp_q.size() != 0) begin
      logic [31:0] epc;
      epc = exp_q.pop_front();
      check("out_pc", pc_o, epc);
      check("out_instr", instr_o, instr_of(epc));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset values, first strobe timing, one instruction per cycle
    output_ready_i = 1'b1;
    apply_reset();
    check("rst_stb", 32'(wb_stb_o), 32'd0);
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_valid", 32'(output_valid_o), 32'd0);
    check("rst_adr", wb_adr_o, 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", pc_o, 32'h1000);
    check("tie_we_sel", {wb_we_o, wb_sel_o}, 32'h0F);
    exp_q.push_back(32'h1000); exp_q.push_back(32'h1004); exp_q.push_back(32'h1008);
    step();
    check("t1_stb", 32'(wb_stb_o), 32'd1);
    check("t1_adr", wb_adr_o, 32'h1000);
    step(); step();
    for (int i = 0; i < 3; i++) begin
      check("t1_valid", 32'(output_valid_o), 32'd1);
      check("t1_pc_seq", pc_o, 32'h1000 + 32'(4 * i));
      step();
    end
    wait_drain("t1_drain");

    // 2: decode stalled -> exactly DEPTH fetches, then in-order drain
    output_ready_i = 1'b0;
    apply_reset();
    repeat (12) step();
    check("t2_accepts", 32'(acc_cnt), 32'd4);
    check("t2_stb_low", 32'(wb_stb_o), 32'd0);
    check("t2_valid", 32'(output_valid_o), 32'd1);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h1000 + 32'(4 * i));
    output_ready_i = 1'b1;
    wait_drain("t2_drain");

    // 3: slave stall holds the request stable, no duplicate fetch
    apply_reset();
    wb_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h1000 + 32'(4 * i));
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_stb_held", 32'(wb_stb_o), 32'd1);
      check("t3_adr_held", wb_adr_o, 32'h1000);
      check("t3_no_accept", 32'(acc_cnt), 32'd0);
    end
    step();
    wb_stall_i = 1'b0;
    wait_drain("t3_drain");

    // 4: branch with two reads in flight -> both responses discarded
    apply_reset();
    ack_hold = 1'b1;
    repeat (4) step();
    check("t4_outstanding", 32'(acc_cnt), 32'd2);
    check("t4_stb_low", 32'(wb_stb_o), 32'd0);
    branch_i = 1'b1; branch_target_i = 32'h2000;
    step();
    branch_i = 1'b0; ack_hold = 1'b0;
    check("t4_flush_valid", 32'(output_valid_o), 32'd0);
    check("t4_flush_stb", 32'(wb_stb_o), 32'd0);
    exp_q.push_back(32'h2000); exp_q.push_back(32'h2004);
    for (int i = 0; i < 3; i++) begin
      check("t4_cyc", 32'(wb_cyc_o), 32'd1);
      step();
    end
    wait_drain("t4_drain");

    // 5: irq beats branch in the same cycle
    apply_reset();
    exp_q.push_back(32'h1000);
    repeat (6) step();
    irq_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h3000;
    step();
    irq_i = 1'b0; branch_i = 1'b0;
    check("t5_flush_valid", 32'(output_valid_o), 32'd0);
    check("t5_flush_stb", 32'(wb_stb_o), 32'd0);
    check("t5_pre_drain", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    wait_drain("t5_drain");

    // 6: reset with reads in flight; late ack after reset is ignored
    apply_reset();
    ack_hold = 1'b1;
    repeat (4) step();
    check("t6_cyc_before", 32'(wb_cyc_o), 32'd1);
    rst_i = 1'b1; ack_hold = 1'b0;
    step();
    rst_i = 1'b0;
    check("t6_cyc", 32'(wb_cyc_o), 32'd0);
    check("t6_stb", 32'(wb_stb_o), 32'd0);
    check("t6_valid", 32'(output_valid_o), 32'd0);
    check("t6_pc", pc_o, 32'h1000);
    exp_q.push_back(32'h1000); exp_q.push_back(32'h1004);
    step();
    check("t6_late_ack", 32'(output_valid_o), 32'd0);
    wait_drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
